// File: rtl/telemetry_tx.sv
// telemetry_tx: periodic telemetry framer and 8N1 UART transmitter.
//
// A free-running period counter fires a trigger every 2^12 (FAST_SIM=1) or
// 2^20 (FAST_SIM=0) clocks. When the transmitter is idle, the trigger snapshots
// the three 12-bit sensor values. The transmitter then sends a fixed packet
// LSB first, idle high, with no gap between bytes:
//    AA 55 {0,batt[11:8]} batt[7:0] {0,curr[11:8]} curr[7:0]
//    {0,torque[11:8]} torque[7:0] [checksum]
//
// Optional feature (macro TLM_CHKSUM_EN): appends a 9th byte holding the
// bitwise NOT of the mod-256 sum of bytes 2..7 of the snapshot.
//
// Ports:
//    clk      in   system clock
//    rst      in   synchronous active-high reset
//    batt     in   [11:0] conditioned battery voltage
//    curr     in   [11:0] conditioned motor current
//    torque   in   [11:0] conditioned pedal torque
//    TX       out  UART serial output (registered)
//    busy     out  high while a packet is being shifted
//    pkt_done out  one-clock pulse after the final stop bit of a packet
module telemetry_tx #(
   parameter int unsigned FAST_SIM = 0,
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] batt,
   input  logic [11:0] curr,
   input  logic [11:0] torque,
   output logic        TX,
   output logic        busy,
   output logic        pkt_done
);

   localparam int unsigned PW = (FAST_SIM != 0) ? 12 : 20;
   localparam int unsigned BW = 12;
   localparam int unsigned IW = 4;
`ifdef TLM_CHKSUM_EN
   localparam int unsigned NBYTES = 9;
`else
   localparam int unsigned NBYTES = 8;
`endif
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   per_q, per_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [11:0]     batt_q, batt_d;
   logic [11:0]     curr_q, curr_d;
   logic [11:0]     torque_q, torque_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
`ifdef TLM_CHKSUM_EN
   logic [7:0]      chk_q, chk_d;
   logic [7:0]      chk_c;
`endif

   logic            trig_c;
   logic            baud_last_c;
   logic [2:0]      bit_nxt_c;
   logic [7:0]      cur_byte_c;

   assign trig_c      = &per_q;
   assign baud_last_c = (baud_q == BAUD_LAST);
   assign bit_nxt_c   = bit_q + 3'd1;

`ifdef TLM_CHKSUM_EN
   // Checksum is taken from the live inputs so it lands with the snapshot.
   always_comb begin
      chk_c = ~({4'h0, batt[11:8]} + batt[7:0] +
                {4'h0, curr[11:8]} + curr[7:0] +
                {4'h0, torque[11:8]} + torque[7:0]);
   end
`endif

   // Select the byte currently being sent from the snapshot.
   always_comb begin
      cur_byte_c = 8'h00;
      case (idx_q)
         4'd0: cur_byte_c = 8'hAA;
         4'd1: cur_byte_c = 8'h55;
         4'd2: cur_byte_c = {4'h0, batt_q[11:8]};
         4'd3: cur_byte_c = batt_q[7:0];
         4'd4: cur_byte_c = {4'h0, curr_q[11:8]};
         4'd5: cur_byte_c = curr_q[7:0];
         4'd6: cur_byte_c = {4'h0, torque_q[11:8]};
         4'd7: cur_byte_c = torque_q[7:0];
`ifdef TLM_CHKSUM_EN
         4'd8: cur_byte_c = chk_q;
`endif
         default: cur_byte_c = 8'h00;
      endcase
   end

   // Next-state and output logic; TX level for the next cycle is decided here
   // so the pin is always driven straight from a flop.
   always_comb begin
      state_d  = state_q;
      per_d    = per_q + PW'(1);
      baud_d   = baud_q;
      bit_d    = bit_q;
      idx_d    = idx_q;
      batt_d   = batt_q;
      curr_d   = curr_q;
      torque_d = torque_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef TLM_CHKSUM_EN
      chk_d    = chk_q;
`endif

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (trig_c) begin
               batt_d   = batt;
               curr_d   = curr;
               torque_d = torque;
`ifdef TLM_CHKSUM_EN
               chk_d    = chk_c;
`endif
               busy_d   = 1'b1;
               idx_d    = '0;
               baud_d   = '0;
               tx_d     = 1'b0;
               state_d  = S_START;
            end
         end

         S_START: begin
            if (baud_last_c) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               tx_d    = cur_byte_c[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end

         S_DATA: begin
            if (baud_last_c) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_nxt_c;
                  tx_d  = cur_byte_c[bit_nxt_c];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end

         S_STOP: begin
            if (baud_last_c) begin
               baud_d = '0;
               if (idx_q == IDX_LAST) begin
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  // Next byte starts immediately: no idle bits in between.
                  idx_d   = idx_q + IW'(1);
                  tx_d    = 1'b0;
                  state_d = S_START;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         per_q    <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
         idx_q    <= '0;
         batt_q   <= '0;
         curr_q   <= '0;
         torque_q <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef TLM_CHKSUM_EN
         chk_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         idx_q    <= idx_d;
         batt_q   <= batt_d;
         curr_q   <= curr_d;
         torque_q <= torque_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef TLM_CHKSUM_EN
         chk_q    <= chk_d;
`endif
      end
   end

   assign TX       = tx_q;
   assign busy     = busy_q;
   assign pkt_done = done_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// tb_telemetry_tx: scoreboard bench for telemetry_tx. Two instances share the
// sensor inputs: one at BAUD_DIV=16 and one at BAUD_DIV=64 (packet longer
// than the trigger period). Expected bytes are queued when stimulus is set
// and popped as the UART stream is decoded.
module tb_telemetry_tx;

`ifdef TLM_CHKSUM_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic [11:0] batt, curr, torque;
   logic        tx_a, busy_a, done_a;
   logic        tx_b, busy_b, done_b;

   bit          sel;
   logic        cur_tx, cur_busy, cur_done;
   longint      cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_q[$];
   longint      first_a, last_a, t0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign cur_tx   = sel ? tx_b   : tx_a;
   assign cur_busy = sel ? busy_b : busy_a;
   assign cur_done = sel ? done_b : done_a;

   telemetry_tx #(.FAST_SIM(1), .BAUD_DIV(16)) dut_a (
      .clk(clk), .rst(rst_a), .batt(batt), .curr(curr), .torque(torque),
      .TX(tx_a), .busy(busy_a), .pkt_done(done_a)
   );

   telemetry_tx #(.FAST_SIM(1), .BAUD_DIV(64)) dut_b (
      .clk(clk), .rst(rst_b), .batt(batt), .curr(curr), .torque(torque),
      .TX(tx_b), .busy(busy_b), .pkt_done(done_b)
   );

   // Queue the expected packet for a given snapshot.
   task automatic push_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
      logic [7:0] s;
      logic [7:0] bytes [0:7];
      bytes[0] = 8'hAA;            bytes[1] = 8'h55;
      bytes[2] = {4'h0, b[11:8]};  bytes[3] = b[7:0];
      bytes[4] = {4'h0, c[11:8]};  bytes[5] = c[7:0];
      bytes[6] = {4'h0, t[11:8]};  bytes[7] = t[7:0];
      s = 8'h00;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(bytes[i]);
         if (i >= 2) s = s + bytes[i];
      end
`ifdef TLM_CHKSUM_EN
      exp_q.push_back(~s);
`endif
   endtask

   // Wait (bounded) for a packet start, decode every byte and check framing,
   // bit width, gap-free sequencing and the pkt_done/busy end-of-packet edge.
   task automatic rx_packet(input bit s, input int bd, input longint exp_start, input string name);
      bit         found;
      int         idle_err, glitch, frame_err, busy_err;
      logic       smp, first;
      logic [7:0] v, e;
      sel = s;
      found = 1'b0;
      idle_err = 0;
      while (!found && cyc <= exp_start + 8) begin
         @(posedge clk); #1;
         if (cur_tx === 1'b0) found = 1'b1;
         else if (cur_busy !== 1'b0 || cur_done !== 1'b0) idle_err++;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL %s start: no start bit by cycle %0d", name, exp_start + 8);
         repeat (NB) if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      total++;
      if (cyc != exp_start) begin
         bad++;
         $display("FAIL %s start_time: got cycle %0d want %0d", name, cyc, exp_start);
      end
      total++;
      if (idle_err != 0) begin
         bad++;
         $display("FAIL %s idle: got %0d busy/done samples before start want 0", name, idle_err);
      end
      for (int k = 0; k < NB; k++) begin
         v = 8'h00; glitch = 0; frame_err = 0; busy_err = 0; first = 1'b0;
         for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < bd; c++) begin
               if (!(k == 0 && b == 0 && c == 0)) begin
                  @(posedge clk); #1;
               end
               smp = cur_tx;
               if (cur_busy !== 1'b1) busy_err++;
               if (c == 0) begin
                  first = smp;
                  if (b == 0 && smp !== 1'b0) frame_err++;
                  if (b == 9 && smp !== 1'b1) frame_err++;
                  if (b >= 1 && b <= 8) v[b-1] = smp;
               end else if (smp !== first) begin
                  glitch++;
               end
            end
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         total++;
         if (v !== e) begin
            bad++;
            $display("FAIL %s byte%0d: got %h want %h", name, k, v, e);
         end
         total++;
         if (glitch != 0 || frame_err != 0 || busy_err != 0) begin
            bad++;
            $display("FAIL %s frame%0d: got glitch=%0d frame=%0d busy=%0d want 0 0 0",
                     name, k, glitch, frame_err, busy_err);
         end
      end
      @(posedge clk); #1;
      total++;
      if (cur_done !== 1'b1 || cur_busy !== 1'b0 || cur_tx !== 1'b1) begin
         bad++;
         $display("FAIL %s end: got done=%b busy=%b tx=%b want 1 0 1", name, cur_done, cur_busy, cur_tx);
      end
      @(posedge clk); #1;
      total++;
      if (cur_done !== 1'b0) begin
         bad++;
         $display("FAIL %s done_pulse: got done=%b one cycle later want 0", name, cur_done);
      end
   endtask

   task automatic test_reset();
      int err;
      sel = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1;
      batt = 12'hABC; curr = 12'h3FF; torque = 12'h2FF;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_a: got tx=%b busy=%b done=%b want 1 0 0", tx_a, busy_a, done_a);
      end
      total++;
      if (tx_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
         bad++;
         $display("FAIL reset_b: got tx=%b busy=%b done=%b want 1 0 0", tx_b, busy_b, done_b);
      end
      @(negedge clk);
      rst_a = 1'b0;
      t0 = cyc;
      err = 0;
      repeat (4095) begin
         @(posedge clk); #1;
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) err++;
      end
      total++;
      if (err != 0) begin
         bad++;
         $display("FAIL idle_period: got %0d non-idle cycles want 0", err);
      end
      first_a = t0 + 4096;
   endtask

   task automatic test_nominal();
      push_pkt(12'hABC, 12'h3FF, 12'h2FF);
      // Change batt while byte 1 is on the wire; the snapshot must hold.
      fork
         begin
            repeat (200) @(posedge clk);
            batt = 12'h123;
         end
      join_none
      rx_packet(1'b0, 16, first_a, "nominal");
   endtask

   task automatic test_snapshot_hold();
      push_pkt(12'h123, 12'h3FF, 12'h2FF);
      rx_packet(1'b0, 16, first_a + 4096, "snapshot");
   endtask

   task automatic test_reset_mid();
      int err;
      sel = 1'b0;
      while (cyc < first_a + 8192 - 1) @(posedge clk);
      @(posedge clk); #1;
      total++;
      if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
         bad++;
         $display("FAIL midrst_start: got tx=%b busy=%b want 0 1", tx_a, busy_a);
      end
      // Byte 3 data bits span offsets 496..623 of the packet.
      repeat (536) @(posedge clk);
      @(negedge clk);
      rst_a = 1'b1;
      @(posedge clk); #1;
      total++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         bad++;
         $display("FAIL midrst: got tx=%b busy=%b done=%b want 1 0 0", tx_a, busy_a, done_a);
      end
      @(negedge clk);
      rst_a = 1'b0;
      t0 = cyc;
      err = 0;
      repeat (4095) begin
         @(posedge clk); #1;
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) err++;
      end
      total++;
      if (err != 0) begin
         bad++;
         $display("FAIL midrst_idle: got %0d non-idle cycles want 0", err);
      end
      push_pkt(12'h123, 12'h3FF, 12'h2FF);
      rx_packet(1'b0, 16, t0 + 4096, "after_reset");
      last_a = t0 + 4096;
   endtask

   task automatic test_zero();
      batt = 12'h000; curr = 12'h000; torque = 12'h000;
      push_pkt(12'h000, 12'h000, 12'h000);
      rx_packet(1'b0, 16, last_a + 4096, "zero");
   endtask

   task automatic test_trig_busy();
      longint tb0;
      batt = 12'h5A5; curr = 12'h0F0; torque = 12'hC3C;
      @(negedge clk);
      rst_b = 1'b0;
      tb0 = cyc;
      push_pkt(12'h5A5, 12'h0F0, 12'hC3C);
      rx_packet(1'b1, 64, tb0 + 4096, "busy_first");
      // Trigger at +4096 falls inside the 5120-clock packet and is dropped.
      push_pkt(12'h5A5, 12'h0F0, 12'hC3C);
      rx_packet(1'b1, 64, tb0 + 4096 + 8192, "busy_third");
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_snapshot_hold();
      test_reset_mid();
      test_zero();
      test_trig_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
